// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, the HALT opcode and the FIFO entry layout live here.
package ifetch_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 16;
  localparam logic [3:0]  OP_HALT = 4'hF;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4] == OP_HALT;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and decode handoff.
// master = fetch stage, slave = surrounding pipeline / memory.
interface ifetch_if;
  import ifetch_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid;
  logic [INST_W-1:0] imem_rdata;
  logic              jmp;
  logic [PC_W-1:0]   jmp_tgt;
  logic              stall;
  logic              inst_valid;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   pc_out;
  logic              eop;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_out, eop,
    input  imem_valid, imem_rdata, jmp, jmp_tgt, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out, eop,
    output imem_valid, imem_rdata, jmp, jmp_tgt, stall
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry instruction/PC buffer between memory responses and decode.
// Flush dominates push and pop; the head entry is always visible on dout.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && !full && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: one request per cycle, 2-entry output buffer, redirect and HALT.
// Define IFETCH_PERF_EN to add the fetch_cnt popped-instruction counter port.
module ifetch_stage
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            discard_q, discard_d;
  logic            halt_seen_q, halt_seen_d;
  logic            eop_q, eop_d;

  logic            jmp_eff, pop, pop_eff, push, push_eff, push_halt, req;
  logic [2:0]      pending;
  fetch_entry_t    resp, head;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_count;

  ifetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (resp),
    .pop   (pop),
    .flush (jmp_eff),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    jmp_eff   = bus.jmp && !eop_q;
    pop       = !fifo_empty && !bus.stall;
    pop_eff   = pop && !jmp_eff;
    push      = bus.imem_valid && inflight_q && !discard_q;
    push_eff  = push && !jmp_eff;
    push_halt = push_eff && is_halt(bus.imem_rdata);
    resp.inst = bus.imem_rdata;
    resp.pc   = req_pc_q;
    // Buffer slots already claimed after this cycle's pop; a new request needs one free.
    pending   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    req       = rst_n && !eop_q && !halt_seen_q && (pending < 3'd2);
  end

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    if (req) begin
      pc_d     = pc_q + 8'd1;
      req_pc_d = pc_q;
    end
    if (jmp_eff) begin
      pc_d = bus.jmp_tgt;
    end
    inflight_d  = req;
    // A request leaving alongside a redirect or a HALT push must never reach the buffer.
    discard_d   = req && (jmp_eff || push_halt);
    halt_seen_d = jmp_eff ? 1'b0 : (halt_seen_q || push_halt);
    eop_d       = eop_q || (pop_eff && is_halt(head.inst));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
      halt_seen_q <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      halt_seen_q <= halt_seen_d;
      eop_q       <= eop_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_out   = head.inst;
  assign bus.pc_out     = head.pc;
  assign bus.eop        = eop_q;

  push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push && fifo_full && !jmp_eff));

`ifdef IFETCH_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (pop_eff && !eop_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: scoreboard of expected {inst, pc} fed per phase,
// drained by a decode model that stalls whenever nothing more is expected.
module tb_ifetch_stage;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_if bus ();

  logic        jmp, stall, inject_valid, halt_en;
  logic [7:0]  jmp_tgt;
  logic [15:0] inject_data;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_cnt;
`endif

  ifetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (halt_en && a == 8'h05) return 16'hF000;
    return 16'h0100 + {8'h00, a};
  endfunction

  // One-cycle-latency instruction memory, plus an injectable stray response.
  always @(posedge clk) begin
    mem_valid <= bus.imem_req;
    mem_rdata <= mem_word(bus.imem_addr);
  end

  assign bus.imem_valid = mem_valid | inject_valid;
  assign bus.imem_rdata = inject_valid ? inject_data : mem_rdata;
  assign bus.jmp        = jmp;
  assign bus.jmp_tgt    = jmp_tgt;
  assign bus.stall      = stall;

  int           checks = 0;
  int           errors = 0;
  fetch_entry_t sb[$];
  logic [7:0]   exp_addr;
  logic         exp_eop;
  int           pop_count;
  logic [7:0]   max_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc   = start + 8'(i);
      e.inst = mem_word(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst_out", bus.inst_out, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_eop", bus.eop, 0);
  endtask

  // One cycle: drive inputs for the coming edge, check outputs, advance the model.
  task automatic step(input logic j, input logic [7:0] tgt, input logic force_stall);
    fetch_entry_t e;
    logic         popping;
    logic         taken;
    @(negedge clk);
    jmp          = j;
    jmp_tgt      = tgt;
    inject_valid = 1'b0;
    stall        = force_stall || (sb.size() == 0);
    #1;
    check("imem_addr", bus.imem_addr, exp_addr);
    check("eop", bus.eop, exp_eop);
`ifdef IFETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, pop_count);
`endif
    if (bus.imem_req && bus.imem_addr > max_req) max_req = bus.imem_addr;
    taken   = j && !exp_eop;
    popping = bus.inst_valid && !stall && !taken;
    if (taken) exp_addr = tgt;
    else if (bus.imem_req) exp_addr = exp_addr + 8'd1;
    if (popping) begin
      e = sb.pop_front();
      check("inst_out", bus.inst_out, e.inst);
      check("pc_out", bus.pc_out, e.pc);
      pop_count++;
      if (e.inst[15:12] == OP_HALT) exp_eop = 1'b1;
    end
  endtask

  task automatic run_drain(input string tag, input int max_steps);
    int n = 0;
    while (sb.size() != 0 && n < max_steps) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    jmp = 1'b0; jmp_tgt = 8'h00; stall = 1'b0;
    inject_valid = 1'b0; inject_data = 16'h0000; halt_en = 1'b0;
    exp_addr = 8'h00; exp_eop = 1'b0; pop_count = 0; max_req = 8'h00;

    // Reset values and first-request latency
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    expect_run(8'h00, 10);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_req", bus.imem_req, 1);
    check("first_addr", bus.imem_addr, 8'h00);
    check("cycle0_inst_valid", bus.inst_valid, 0);
    exp_addr = 8'h01;
    step(1'b0, 8'h00, 1'b0);
    check("cycle1_inst_valid", bus.inst_valid, 0);
    step(1'b0, 8'h00, 1'b0);
    check("cycle2_inst_valid", bus.inst_valid, 1);
    repeat (9) step(1'b0, 8'h00, 1'b0);
    check("one_per_cycle", sb.size(), 0);

    // Decode stall: outputs frozen, buffer fills, requests stop
    step(1'b0, 8'h00, 1'b0);
    check("stall_head_pc", bus.pc_out, 8'h0A);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("stall_pc_held", bus.pc_out, 8'h0A);
    check("stall_inst_held", bus.inst_out, 16'h010A);
    check("stall_valid_held", bus.inst_valid, 1);
    check("stall_req_drop", bus.imem_req, 0);
    expect_run(8'h0A, 10);
    run_drain("stall_release_drain", 30);

    // Redirect with a response in flight
    expect_run(8'h14, 10);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    sb.delete();
    expect_run(8'h40, 8);
    step(1'b0, 8'h00, 1'b0);
    check("jmp_req", bus.imem_req, 1);
    check("jmp_addr", bus.imem_addr, 8'h40);
    check("jmp_flushed", bus.inst_valid, 0);
    step(1'b0, 8'h00, 1'b0);
    check("jmp_inflight_dropped", bus.inst_valid, 0);
    run_drain("jmp_drain", 30);

    // Redirect beats stall with a full buffer
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("full_req_drop", bus.imem_req, 0);
    check("full_head_pc", bus.pc_out, 8'h48);
    step(1'b1, 8'h80, 1'b1);
    expect_run(8'h80, 4);
    step(1'b0, 8'h00, 1'b0);
    check("flush_empty", bus.inst_valid, 0);
    check("flush_req", bus.imem_req, 1);
    check("flush_addr", bus.imem_addr, 8'h80);
    run_drain("flush_drain", 30);

    // PC wrap 8'hFF -> 8'h00
    repeat (2) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hFD, 1'b0);
    sb.delete();
    expect_run(8'hFD, 5);
    run_drain("wrap_drain", 30);
    step(1'b0, 8'h00, 1'b0);
    check("wrap_next_head", bus.pc_out, 8'h02);

    // Reset mid-operation with a request outstanding
    expect_run(8'h02, 2);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
`ifdef IFETCH_PERF_EN
    check("rst_fetch_cnt", fetch_cnt, 0);
`endif
    halt_en = 1'b1;
    sb.delete();
    exp_addr = 8'h00; exp_eop = 1'b0; pop_count = 0; max_req = 8'h00;
    stall = 1'b0; jmp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    inject_valid = 1'b1;
    inject_data  = 16'hF000;
    #1;
    check("rerst_req", bus.imem_req, 1);
    check("rerst_addr", bus.imem_addr, 8'h00);
    exp_addr = 8'h01;
    expect_run(8'h00, 6);
    step(1'b0, 8'h00, 1'b0);
    check("stray_valid_ignored", bus.inst_valid, 0);

    // HALT at 8'h05: fetch stops at 8'h06, eop sticky, redirect ignored
    run_drain("halt_drain", 20);
    step(1'b0, 8'h00, 1'b0);
    check("eop_set", bus.eop, 1);
    check("halt_max_req", max_req, 8'h06);
    check("halt_no_req", bus.imem_req, 0);
    check("halt_no_extra_word", bus.inst_valid, 0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("eop_jmp_no_req", bus.imem_req, 0);
    check("eop_jmp_addr", bus.imem_addr, 8'h07);
    check("eop_jmp_valid", bus.inst_valid, 0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("eop_sticky", bus.eop, 1);
    check("eop_max_req", max_req, 8'h06);
`ifdef IFETCH_PERF_EN
    check("fetch_cnt_final", fetch_cnt, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
